// File: rtl/ravenoc_pkg.sv
// Shared NoC constants and types for the output-port scheduler.
// VC count/priority constants plus the per-VC wormhole lock record.
package ravenoc_pkg;

  localparam int unsigned NumVirtChn = 2;
  localparam int unsigned VcWidth    = (NumVirtChn > 1) ? $clog2(NumVirtChn) : 1;
  localparam int unsigned OwnerWidth = 2;

  typedef enum logic {
    ZeroHighPrior = 1'b0,
    ZeroLowPrior  = 1'b1
  } vc_prior_e;

  localparam vc_prior_e HighPriority = ZeroLowPrior;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } vc_lock_state_e;

  typedef struct packed {
    vc_lock_state_e        locked;
    logic [OwnerWidth-1:0] owner;
  } s_vc_lock_t;

  function automatic int unsigned wrap_inc(input int unsigned x, input int unsigned n);
    return (x + 1) % n;
  endfunction

endpackage

// File: rtl/vc_credit_counter.sv
// Per-VC downstream credit counter: saturating up/down with sticky overflow flag.
module vc_credit_counter #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       arst,
  input  logic                       dec,
  input  logic                       inc,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       err
);

  localparam int unsigned W = $clog2(DEPTH + 1);

  always_ff @(posedge clk) begin
    if (!arst) begin
      count <= W'(DEPTH);
      err   <= 1'b0;
    end else begin
      // Simultaneous send and return cancel out, even at the full level.
      if (inc && !dec) begin
        if (count == W'(DEPTH)) begin
          err <= 1'b1;
        end else begin
          count <= count + W'(1);
        end
      end else if (dec && !inc) begin
        if (count != '0) begin
          count <= count - W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/vc_output_scheduler.sv
// Output-port flit scheduler: per-VC wormhole lock, RR among inputs, VC priority, credits.
// Optional RAVENOC_VC_AGING_EN adds per-VC starvation counters overriding fixed priority.
module vc_output_scheduler
  import ravenoc_pkg::*;
#(
  parameter int unsigned N_INPUTS     = 4,
  parameter int unsigned CREDIT_DEPTH = 4,
  parameter int unsigned AGE_LIMIT    = 16
) (
  input  logic                               clk,
  input  logic                               arst,
  input  logic [N_INPUTS-1:0]                req_valid_i,
  input  logic [N_INPUTS-1:0][VcWidth-1:0]   req_vc_i,
  input  logic [N_INPUTS-1:0]                req_last_i,
  input  logic [NumVirtChn-1:0]              credit_i,
  output logic [N_INPUTS-1:0]                gnt_o,
  output logic [VcWidth-1:0]                 gnt_vc_o,
  output logic                               send_o,
  output logic                               credit_err_o
);

  localparam int unsigned CntW = $clog2(CREDIT_DEPTH + 1);

  if (AGE_LIMIT == 0 || N_INPUTS < 2 || N_INPUTS > (1 << OwnerWidth)) begin : g_param_check
    $error("vc_output_scheduler: unsupported N_INPUTS/AGE_LIMIT");
  end

  s_vc_lock_t            lock_q [NumVirtChn];
  s_vc_lock_t            lock_d [NumVirtChn];
  logic [OwnerWidth-1:0] ptr_q  [NumVirtChn];
  logic [OwnerWidth-1:0] ptr_d  [NumVirtChn];
  logic [OwnerWidth-1:0] cand_idx [NumVirtChn];
  logic [NumVirtChn-1:0] cand_found;
  logic [NumVirtChn-1:0] has_cred;
  logic [NumVirtChn-1:0] eligible;
  logic [NumVirtChn-1:0] err;
  logic                  sel_found;
  logic [VcWidth-1:0]    sel_vc;
  logic [OwnerWidth-1:0] win;

  always_comb begin
    for (int unsigned v = 0; v < NumVirtChn; v++) begin
      cand_found[v] = 1'b0;
      cand_idx[v]   = '0;
      if (lock_q[v].locked == LOCKED) begin
        if (req_valid_i[lock_q[v].owner] && req_vc_i[lock_q[v].owner] == VcWidth'(v)) begin
          cand_found[v] = 1'b1;
          cand_idx[v]   = lock_q[v].owner;
        end
      end else begin
        for (int unsigned k = 0; k < N_INPUTS; k++) begin
          if (!cand_found[v] &&
              req_valid_i[(int'(ptr_q[v]) + k) % N_INPUTS] &&
              req_vc_i[(int'(ptr_q[v]) + k) % N_INPUTS] == VcWidth'(v)) begin
            cand_found[v] = 1'b1;
            cand_idx[v]   = OwnerWidth'((int'(ptr_q[v]) + k) % N_INPUTS);
          end
        end
      end
    end
  end

  for (genvar v = 0; v < NumVirtChn; v++) begin : g_credit
    logic [CntW-1:0] count;
    vc_credit_counter #(
      .DEPTH(CREDIT_DEPTH)
    ) u_cnt (
      .clk   (clk),
      .arst  (arst),
      .dec   (send_o && (sel_vc == VcWidth'(v))),
      .inc   (credit_i[v]),
      .count (count),
      .err   (err[v])
    );
    assign has_cred[v] = (count != '0);
  end

  assign eligible     = cand_found & has_cred;
  assign credit_err_o = |err;

`ifdef RAVENOC_VC_AGING_EN
  localparam int unsigned AgeW = $clog2(AGE_LIMIT + 1);
  logic [AgeW-1:0] age_q [NumVirtChn];

  always_ff @(posedge clk) begin
    if (!arst) begin
      for (int unsigned v = 0; v < NumVirtChn; v++) age_q[v] <= '0;
    end else begin
      for (int unsigned v = 0; v < NumVirtChn; v++) begin
        if (send_o && sel_vc == VcWidth'(v)) begin
          age_q[v] <= '0;
        end else if (eligible[v] && age_q[v] < AgeW'(AGE_LIMIT)) begin
          age_q[v] <= age_q[v] + AgeW'(1);
        end
      end
    end
  end
`endif

  always_comb begin
    sel_found = 1'b0;
    sel_vc    = '0;
    if (HighPriority == ZeroLowPrior) begin
      for (int unsigned v = 0; v < NumVirtChn; v++) begin
        if (eligible[v]) begin
          sel_found = 1'b1;
          sel_vc    = VcWidth'(v);
        end
      end
    end else begin
      for (int unsigned v = NumVirtChn; v > 0; v--) begin
        if (eligible[v-1]) begin
          sel_found = 1'b1;
          sel_vc    = VcWidth'(v - 1);
        end
      end
    end
`ifdef RAVENOC_VC_AGING_EN
    // Descending scan so the lowest starving VC is the last to overwrite.
    for (int unsigned v = NumVirtChn; v > 0; v--) begin
      if (eligible[v-1] && age_q[v-1] >= AgeW'(AGE_LIMIT)) begin
        sel_vc = VcWidth'(v - 1);
      end
    end
`endif
  end

  assign win      = cand_idx[sel_vc];
  assign send_o   = arst && sel_found;
  assign gnt_o    = send_o ? (N_INPUTS'(1) << win) : '0;
  assign gnt_vc_o = send_o ? sel_vc : '0;

  always_comb begin
    for (int unsigned v = 0; v < NumVirtChn; v++) begin
      lock_d[v] = lock_q[v];
      ptr_d[v]  = ptr_q[v];
    end
    if (send_o) begin
      if (req_last_i[win]) begin
        lock_d[sel_vc].locked = UNLOCKED;
        ptr_d[sel_vc]         = OwnerWidth'(wrap_inc(int'(win), N_INPUTS));
      end else begin
        lock_d[sel_vc] = '{locked: LOCKED, owner: win};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!arst) begin
      for (int unsigned v = 0; v < NumVirtChn; v++) begin
        lock_q[v] <= '{locked: UNLOCKED, owner: '0};
        ptr_q[v]  <= '0;
      end
    end else begin
      lock_q <= lock_d;
      ptr_q  <= ptr_d;
    end
  end

endmodule
